// File: rtl/dds_pkg.sv
// Shared types and defaults for the DDS frame sequencer.
package dds_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACC,
        LOAD,
        SHIFT,
        GAP
    } state_t;

    localparam int unsigned DDS_PERIOD = 19;
    localparam int unsigned DDS_DATA_W = 16;
    localparam int unsigned DDS_CNT_W  = 5;

    // A frame needs ACC + LOAD + DATA_W shift cycles + at least one GAP cycle.
    function automatic bit frame_fits(input int unsigned period, input int unsigned data_w);
        return period >= data_w + 3;
    endfunction

endpackage

// File: rtl/dds_piso.sv
// Parallel-load, MSB-first shift register with zero fill feeding the serial DAC.
module dds_piso #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] pdata,
    output logic              sdata
);

    logic [DATA_W-1:0] sreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= pdata;
        end else if (shift) begin
            sreg <= {sreg[DATA_W-2:0], 1'b0};
        end
    end

    // Zero fill leaves the register empty after a full word, so the MSB idles low.
    assign sdata = sreg[DATA_W-1];

endmodule

// File: rtl/dds_frame_sequencer.sv
// One DDS sample per PERIOD-cycle frame: accumulator strobe, sample latch,
// MSB-first serial shift under chip select, then a guard gap.
module dds_frame_sequencer
    import dds_pkg::*;
#(
    parameter int unsigned PERIOD = DDS_PERIOD,
    parameter int unsigned DATA_W = DDS_DATA_W,
    parameter int unsigned CNT_W  = DDS_CNT_W
) (
    input  logic              clkI,
    input  logic              rstI,
    input  logic              enI,
    input  logic [DATA_W-1:0] sampleI,
    output logic              accEnO,
    output logic              csnO,
    output logic              sdataO,
    output logic              doneO,
    output logic              busyO
);

    if (!frame_fits(PERIOD, DATA_W)) begin : g_bad_period
        $error("PERIOD must be at least DATA_W + 3");
    end
    if ((64'd1 << CNT_W) < 64'(PERIOD)) begin : g_bad_cnt_w
        $error("CNT_W too narrow for PERIOD");
    end

    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_GAP   = CNT_W'(PERIOD - 1);

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             acc_d, csn_d, done_d, busy_d;

    always_ff @(posedge clkI) begin
        if (rstI) begin
            state  <= IDLE;
            cnt    <= '0;
            accEnO <= 1'b0;
            csnO   <= 1'b1;
            doneO  <= 1'b0;
            busyO  <= 1'b0;
        end else begin
            state  <= next_state;
            cnt    <= cnt_d;
            accEnO <= acc_d;
            csnO   <= csn_d;
            doneO  <= done_d;
            busyO  <= busy_d;
        end
    end

    // Outputs are decoded from next_state so the registered strobes line up
    // with the state register: cnt equals the frame-relative cycle number.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (enI) next_state = ACC;
            ACC:     next_state = LOAD;
            LOAD:    next_state = SHIFT;
            SHIFT:   if (cnt == LAST_SHIFT) next_state = GAP;
            GAP:     if (cnt == LAST_GAP) next_state = enI ? ACC : IDLE;
            default: next_state = IDLE;
        endcase

        cnt_d  = (next_state == IDLE || next_state == ACC) ? '0 : cnt + CNT_W'(1);
        acc_d  = (next_state == ACC);
        csn_d  = (next_state != SHIFT);
        done_d = (state == SHIFT) && (next_state == GAP);
        busy_d = (next_state != IDLE);
    end

    dds_piso #(
        .DATA_W(DATA_W)
    ) u_piso (
        .clk  (clkI),
        .rst  (rstI),
        .load (state == LOAD),
        .shift(state == SHIFT),
        .pdata(sampleI),
        .sdata(sdataO)
    );

endmodule

// File: tb/tb_dds_frame_sequencer.sv
// Scoreboard bench: default instance (PERIOD 19, DATA_W 16) and minimum-legal
// instance (PERIOD 18, DATA_W 15); monitors check every presented frame.
module tb_dds_frame_sequencer;

    typedef struct {
        logic [15:0] word;
        int          spacing;   // expected distance from previous accEnO, 0 = unchecked
    } frame_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en0 = 1'b0, en1 = 1'b0;
    logic [15:0] samp0 = '0;
    logic [14:0] samp1 = '0;
    logic        acc0, csn0, sd0, done0, busy0;
    logic        acc1, csn1, sd1, done1, busy1;
    logic        acc_s[2], csn_s[2], sdata_s[2], done_s[2], busy_s[2];

    frame_t exp_q[2][$];
    int     tests = 0;
    int     fails = 0;

    always #10 clk = ~clk;

    dds_frame_sequencer dut0 (
        .clkI(clk), .rstI(rst), .enI(en0), .sampleI(samp0),
        .accEnO(acc0), .csnO(csn0), .sdataO(sd0), .doneO(done0), .busyO(busy0)
    );

    dds_frame_sequencer #(.PERIOD(18), .DATA_W(15), .CNT_W(5)) dut1 (
        .clkI(clk), .rstI(rst), .enI(en1), .sampleI(samp1),
        .accEnO(acc1), .csnO(csn1), .sdataO(sd1), .doneO(done1), .busyO(busy1)
    );

    assign acc_s[0] = acc0;  assign csn_s[0] = csn0;  assign sdata_s[0] = sd0;
    assign done_s[0] = done0; assign busy_s[0] = busy0;
    assign acc_s[1] = acc1;  assign csn_s[1] = csn1;  assign sdata_s[1] = sd1;
    assign done_s[1] = done1; assign busy_s[1] = busy1;

    function automatic int dw(input int k);
        return (k == 0) ? 16 : 15;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    task automatic flag(input string name);
        tests++;
        fails++;
        $display("FAIL %s: got event, expected none", name);
    endtask

    task automatic monitor(input int k);
        int          cyc = 0;
        int          last_acc = 0;
        int          nbits = 0;
        logic [15:0] w = '0;
        frame_t      f;
        int          mask;
        mask = (1 << dw(k)) - 1;
        forever begin
            @(negedge clk);
            cyc++;
            if (acc_s[k]) begin
                if (exp_q[k].size() == 0)
                    flag($sformatf("i%0d unexpected accEnO", k));
                else if (exp_q[k][0].spacing != 0)
                    chk($sformatf("i%0d accEnO spacing", k), cyc - last_acc, exp_q[k][0].spacing);
                last_acc = cyc;
                nbits = 0;
                w = '0;
            end
            if (!csn_s[k]) begin
                w = {w[14:0], sdata_s[k]};
                nbits++;
            end else if (sdata_s[k] !== 1'b0) begin
                chk($sformatf("i%0d sdataO idle", k), int'(sdata_s[k]), 0);
            end
            if (done_s[k]) begin
                if (exp_q[k].size() == 0) begin
                    flag($sformatf("i%0d unexpected doneO", k));
                end else begin
                    f = exp_q[k].pop_front();
                    chk($sformatf("i%0d serial word", k), int'(w) & mask, int'(f.word) & mask);
                    chk($sformatf("i%0d csnO low cycles", k), nbits, dw(k));
                    chk($sformatf("i%0d doneO offset", k), cyc - last_acc, dw(k) + 2);
                    chk($sformatf("i%0d csnO at doneO", k), int'(csn_s[k]), 1);
                end
            end
        end
    endtask

    task automatic wait_acc(input int k, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!acc_s[k] && n < 100);
        if (!acc_s[k]) chk($sformatf("i%0d accEnO timeout", k), 0, 1);
    endtask

    task automatic wait_idle(input int k, output int n);
        n = 0;
        forever begin
            @(negedge clk);
            if (!busy_s[k] || n >= 100) break;
            n++;
        end
        if (busy_s[k]) chk($sformatf("i%0d busyO timeout", k), 1, 0);
    endtask

    task automatic chk_reset(input int k, input string tag);
        chk($sformatf("%s i%0d accEnO", tag, k), int'(acc_s[k]), 0);
        chk($sformatf("%s i%0d csnO", tag, k), int'(csn_s[k]), 1);
        chk($sformatf("%s i%0d sdataO", tag, k), int'(sdata_s[k]), 0);
        chk($sformatf("%s i%0d doneO", tag, k), int'(done_s[k]), 0);
        chk($sformatf("%s i%0d busyO", tag, k), int'(busy_s[k]), 0);
    endtask

    task automatic push(input int k, input logic [15:0] word, input int spacing);
        frame_t f;
        f.word = word;
        f.spacing = spacing;
        exp_q[k].push_back(f);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        fork
            monitor(0);
            monitor(1);
        join_none
    end

    initial begin
        int n;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_reset(0, "reset");
        chk_reset(1, "reset");

        // Back-to-back frames with enI held high
        samp0 = 16'hA5C3;
        push(0, 16'hA5C3, 0);
        push(0, 16'hA5C3, 19);
        push(0, 16'hA5C3, 19);
        en0 = 1'b1;
        wait_acc(0, n); chk("enI to accEnO latency", n, 1);
        wait_acc(0, n); chk("frame 2 accEnO", n, 19);
        wait_acc(0, n); chk("frame 3 accEnO", n, 19);
        en0 = 1'b0;
        wait_idle(0, n); chk("last frame busy cycles", n + 1, 19);
        idle_cycles(25);

        // Single-cycle enI pulse; sampleI only 0x0001 during LOAD
        push(0, 16'h0001, 0);
        samp0 = 16'hFFFF;
        en0 = 1'b1;
        wait_acc(0, n); chk("pulse latency", n, 1);
        en0 = 1'b0;
        @(negedge clk); samp0 = 16'h0001;
        @(negedge clk); samp0 = 16'hFFFF;
        wait_idle(0, n); chk("single frame busy cycles", n + 3, 19);
        chk("csnO after frame", int'(csn0), 1);
        idle_cycles(25);

        // enI dropped during SHIFT bit 5: frame still completes
        push(0, 16'h9E37, 0);
        samp0 = 16'h9E37;
        en0 = 1'b1;
        wait_acc(0, n);
        idle_cycles(7);
        en0 = 1'b0;
        wait_idle(0, n); chk("dropped-en busy cycles", n + 8, 19);
        idle_cycles(25);

        // Reset during SHIFT bit 8, then a fresh frame with enI still high
        push(0, 16'h5A3C, 0);
        samp0 = 16'h5A3C;
        en0 = 1'b1;
        wait_acc(0, n);
        idle_cycles(10);
        rst = 1'b1;
        @(negedge clk);
        chk_reset(0, "mid-shift reset");
        exp_q[0].delete();
        push(0, 16'hC35A, 0);
        samp0 = 16'hC35A;
        rst = 1'b0;
        wait_acc(0, n); chk("restart latency", n, 1);
        en0 = 1'b0;
        wait_idle(0, n); chk("restart busy cycles", n + 1, 19);
        idle_cycles(25);

        // Minimum-legal geometry: 1-cycle GAP, 18-cycle spacing
        samp1 = 15'h5B2D;
        push(1, 16'h5B2D, 0);
        push(1, 16'h5B2D, 18);
        push(1, 16'h5B2D, 18);
        en1 = 1'b1;
        wait_acc(1, n); chk("i1 latency", n, 1);
        wait_acc(1, n); chk("i1 frame 2 accEnO", n, 18);
        wait_acc(1, n); chk("i1 frame 3 accEnO", n, 18);
        en1 = 1'b0;
        wait_idle(1, n); chk("i1 busy cycles", n + 1, 18);
        idle_cycles(30);

        chk("i0 frames outstanding", exp_q[0].size(), 0);
        chk("i1 frames outstanding", exp_q[1].size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
